// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operation codes, trap causes and the decoded instruction class.
package multi_cycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_e;

    typedef enum logic [2:0] {
        IC_NONE  = 3'd0,
        IC_R     = 3'd1,
        IC_I     = 3'd2,
        IC_LOAD  = 3'd3,
        IC_STORE = 3'd4,
        IC_ECALL = 3'd5
    } iclass_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;

    localparam logic [3:0] CC_AND  = 4'b0000;
    localparam logic [3:0] CC_OR   = 4'b0001;
    localparam logic [3:0] CC_ADD  = 4'b0010;
    localparam logic [3:0] CC_XOR  = 4'b0011;
    localparam logic [3:0] CC_SLL  = 4'b0100;
    localparam logic [3:0] CC_SRL  = 4'b0101;
    localparam logic [3:0] CC_SUB  = 4'b0110;
    localparam logic [3:0] CC_SLT  = 4'b0111;
    localparam logic [3:0] CC_SRA  = 4'b1000;
    localparam logic [3:0] CC_SLTU = 4'b1001;

    // ALU code for the base (funct7 = 0) form of each funct3
    function automatic logic [3:0] base_alu_cc(input logic [2:0] funct3);
        logic [3:0] cc;
        case (funct3)
            3'b000:  cc = CC_ADD;
            3'b001:  cc = CC_SLL;
            3'b010:  cc = CC_SLT;
            3'b011:  cc = CC_SLTU;
            3'b100:  cc = CC_XOR;
            3'b101:  cc = CC_SRL;
            3'b110:  cc = CC_OR;
            3'b111:  cc = CC_AND;
            default: cc = CC_ADD;
        endcase
        return cc;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_cc_decode.sv
// Combinational instruction decode: opcode/funct3/funct7 to ALU code,
// instruction class and illegal-instruction flag.
module alu_cc_decode
    import multi_cycle_controller_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_cc,
    output iclass_e    iclass,
    output logic       illegal
);

    // Classify the instruction and pick its ALU operation
    always_comb begin
        alu_cc  = CC_ADD;
        iclass  = IC_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                iclass = IC_R;
                if (funct7 == F7_BASE) begin
                    alu_cc = base_alu_cc(funct3);
                end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
                    alu_cc = CC_SUB;
                end else if ((funct7 == F7_ALT) && (funct3 == F3_SR)) begin
                    alu_cc = CC_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                iclass = IC_I;
                // Only shifts carry an encoding in funct7; elsewhere it is immediate
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    if (funct7 == F7_BASE) begin
                        alu_cc = base_alu_cc(funct3);
                    end else if ((funct7 == F7_ALT) && (funct3 == F3_SR)) begin
                        alu_cc = CC_SRA;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    alu_cc = base_alu_cc(funct3);
                end
            end
            OP_LOAD: begin
                iclass  = IC_LOAD;
                illegal = (funct3 != F3_WORD);
            end
            OP_STORE: begin
                iclass  = IC_STORE;
                illegal = (funct3 != F3_WORD);
            end
            OP_ECALL: begin
                iclass = IC_ECALL;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 subset control FSM: fetch/decode/execute/memory/writeback
// with sticky halt and trap states and a retired-instruction counter.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int ALU_CC_W    = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                alu_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic [ALU_CC_W-1:0] alu_cc,
    output logic [2:0]          state,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e                state_r;
    iclass_e               iclass_r;
    logic                  run_r;
    logic [3:0]            alu_cc_lat_r;
    logic [WAIT_W-1:0]     wait_cnt_r;
    logic                  ir_write_r;
    logic                  pc_write_r;
    logic                  reg_write_r;
    logic                  alu_src_r;
    logic                  mem_read_r;
    logic                  mem_write_r;
    logic                  mem_to_reg_r;
    logic [ALU_CC_W-1:0]   alu_cc_r;
    logic                  trap_r;
    trap_cause_e           trap_cause_r;
    logic                  halted_r;
    logic [CNT_W-1:0]      instr_count_r;

    logic [3:0]            dec_alu_cc_s;
    iclass_e               dec_iclass_s;
    logic                  dec_illegal_s;
    logic                  store_done_s;
    logic                  is_mem_s;

    alu_cc_decode u_alu_cc_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_cc  (dec_alu_cc_s),
        .iclass  (dec_iclass_s),
        .illegal (dec_illegal_s)
    );

    // A store retires in the very cycle memory acknowledges it
    assign store_done_s = (state_r == ST_MEMORY) && (iclass_r == IC_STORE) && mem_ready;
    assign is_mem_s     = (iclass_r == IC_LOAD) || (iclass_r == IC_STORE);

    // Control FSM with registered datapath controls and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            iclass_r     <= IC_NONE;
            run_r        <= 1'b0;
            alu_cc_lat_r <= 4'b0000;
            wait_cnt_r   <= '0;
            ir_write_r   <= 1'b0;
            pc_write_r   <= 1'b0;
            reg_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            alu_cc_r     <= '0;
            trap_r       <= 1'b0;
            trap_cause_r <= CAUSE_NONE;
            halted_r     <= 1'b0;
        end else begin
            ir_write_r   <= 1'b0;
            pc_write_r   <= 1'b0;
            reg_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            alu_cc_r     <= '0;
            case (state_r)
                ST_FETCH: begin
                    // First edge out of reset opens the first real fetch cycle
                    if (!run_r) begin
                        run_r      <= 1'b1;
                        ir_write_r <= 1'b1;
                    end else begin
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    iclass_r     <= dec_iclass_s;
                    alu_cc_lat_r <= dec_alu_cc_s;
                    if (dec_illegal_s) begin
                        state_r      <= ST_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_ILLEGAL;
                    end else if (dec_iclass_s == IC_ECALL) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r   <= ST_EXECUTE;
                        alu_src_r <= (dec_iclass_s != IC_R);
                        alu_cc_r  <= ALU_CC_W'(dec_alu_cc_s);
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem_s) begin
                        state_r     <= ST_MEMORY;
                        wait_cnt_r  <= '0;
                        alu_src_r   <= 1'b1;
                        alu_cc_r    <= ALU_CC_W'(alu_cc_lat_r);
                        mem_read_r  <= (iclass_r == IC_LOAD);
                        mem_write_r <= (iclass_r == IC_STORE);
                    end else begin
                        state_r     <= ST_WRITEBACK;
                        reg_write_r <= 1'b1;
                        pc_write_r  <= 1'b1;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        if (iclass_r == IC_LOAD) begin
                            state_r      <= ST_WRITEBACK;
                            reg_write_r  <= 1'b1;
                            pc_write_r   <= 1'b1;
                            mem_to_reg_r <= 1'b1;
                        end else begin
                            state_r    <= ST_FETCH;
                            ir_write_r <= 1'b1;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r      <= ST_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + WAIT_W'(1);
                        alu_src_r   <= 1'b1;
                        alu_cc_r    <= ALU_CC_W'(alu_cc_lat_r);
                        mem_read_r  <= (iclass_r == IC_LOAD);
                        mem_write_r <= (iclass_r == IC_STORE);
                    end
                end
                ST_WRITEBACK: begin
                    state_r    <= ST_FETCH;
                    ir_write_r <= 1'b1;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                default: begin
                    state_r      <= ST_TRAP;
                    trap_r       <= 1'b1;
                    trap_cause_r <= CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    // Retired-instruction counter, one step per PC advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count_r <= '0;
        end else if (pc_write) begin
            instr_count_r <= instr_count_r + CNT_W'(1);
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    assign ir_write    = ir_write_r;
    assign pc_write    = pc_write_r | store_done_s;
    assign reg_write   = reg_write_r;
    assign alu_src     = alu_src_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_to_reg  = mem_to_reg_r;
    assign alu_cc      = alu_cc_r;
    assign state       = state_r;
    assign trap        = trap_r;
    assign trap_cause  = trap_cause_r;
    assign halted      = halted_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed scoreboard bench for multi_cycle_controller: per-cycle expected
// state/control traces are queued with their Mem_Ready stimulus and compared.
module tb_multi_cycle_controller;

    localparam logic [6:0] C_IR  = 7'b1000000;
    localparam logic [6:0] C_PC  = 7'b0100000;
    localparam logic [6:0] C_RW  = 7'b0010000;
    localparam logic [6:0] C_SRC = 7'b0001000;
    localparam logic [6:0] C_MR  = 7'b0000100;
    localparam logic [6:0] C_MW  = 7'b0000010;
    localparam logic [6:0] C_M2R = 7'b0000001;
    localparam logic [3:0] FL_ILL  = 4'b1010;
    localparam logic [3:0] FL_TMO  = 4'b1100;
    localparam logic [3:0] FL_HALT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_ready;
    logic       ir_write, pc_write, reg_write, alu_src;
    logic       mem_read, mem_write, mem_to_reg;
    logic [3:0] alu_cc;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
    logic       halted;
    logic [2:0] instr_count;

    typedef struct packed {
        logic       mr;
        logic [2:0] st;
        logic [6:0] ctrl;
        logic [3:0] cc;
        logic [3:0] flags;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string tag;

    always #5 clk = ~clk;

    multi_cycle_controller #(.ALU_CC_W(4), .CNT_W(3), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_cc(alu_cc),
        .state(state), .trap(trap), .trap_cause(trap_cause), .halted(halted),
        .instr_count(instr_count)
    );

    task automatic push(input logic mr, input logic [2:0] st, input logic [6:0] ctrl,
                        input logic [3:0] cc, input logic [3:0] flags);
        exp_t e;
        e.mr = mr; e.st = st; e.ctrl = ctrl; e.cc = cc; e.flags = flags;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Pop one expected cycle at a time, drive its Mem_Ready, compare at negedge
    task automatic run_trace();
        int cyc;
        exp_t e;
        logic [17:0] obs;
        logic [17:0] expv;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            @(negedge clk);
            obs  = {state, ir_write, pc_write, reg_write, alu_src, mem_read, mem_write,
                    mem_to_reg, alu_cc, trap, trap_cause, halted};
            expv = {e.st, e.ctrl, e.cc, e.flags};
            n_cmp++;
            assert (obs === expv) else begin
                n_err++;
                $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 R, 1 I-ALU, 2 load, 3 store
    task automatic instr(input string t, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int kind, input logic [3:0] cc,
                         input int waits);
        logic [6:0] src;
        logic [6:0] mc;
        tag = t; opcode = op; funct3 = f3; funct7 = f7;
        src = (kind != 0) ? C_SRC : 7'b0000000;
        mc  = (kind == 2) ? C_MR : C_MW;
        push(1'b1, 3'd0, C_IR, 4'b0000, 4'b0000);
        push(1'b1, 3'd1, 7'b0000000, 4'b0000, 4'b0000);
        push(1'b1, 3'd2, src, cc, 4'b0000);
        if (kind <= 1) begin
            push(1'b1, 3'd4, C_RW | C_PC, 4'b0000, 4'b0000);
        end else begin
            for (int i = 0; i < waits; i++) push(1'b0, 3'd3, src | mc, cc, 4'b0000);
            push(1'b1, 3'd3, src | mc | ((kind == 3) ? C_PC : 7'b0000000), cc, 4'b0000);
            if (kind == 2) push(1'b1, 3'd4, C_RW | C_PC | C_M2R, 4'b0000, 4'b0000);
        end
        run_trace();
    endtask

    task automatic illegal_instr(input string t, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7);
        tag = t; opcode = op; funct3 = f3; funct7 = f7;
        push(1'b1, 3'd0, C_IR, 4'b0000, 4'b0000);
        push(1'b1, 3'd1, 7'b0000000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++)
            push(1'($urandom_range(0, 1)), 3'd6, 7'b0000000, 4'b0000, FL_ILL);
        run_trace();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0;
        opcode = 7'b0000000; funct3 = 3'b000; funct7 = 7'b0000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({state, ir_write, pc_write, reg_write, alu_src, mem_read,
             mem_write, mem_to_reg, alu_cc, trap, trap_cause, halted}), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        instr("add_x3_x1_x2", 7'b0110011, 3'b000, 7'b0000000, 0, 4'b0010, 0);
        chk("count_add", 32'(instr_count), 32'd1);
        instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0, 4'b0110, 0);
        instr("srai", 7'b0010011, 3'b101, 7'b0100000, 1, 4'b1000, 0);
        instr("xori_imm_f7", 7'b0010011, 3'b100, 7'b1111111, 1, 4'b0011, 0);
        chk("count_alu4", 32'(instr_count), 32'd4);
        instr("lw_wait3", 7'b0000011, 3'b010, 7'b0000000, 2, 4'b0010, 3);
        chk("count_lw", 32'(instr_count), 32'd5);
        instr("sw_wait2", 7'b0100011, 3'b010, 7'b0000000, 3, 4'b0010, 2);
        instr("sw_wait0", 7'b0100011, 3'b010, 7'b0000000, 3, 4'b0010, 0);
        chk("count_sw", 32'(instr_count), 32'd7);

        illegal_instr("illegal_opcode", 7'b1111111, 3'b000, 7'b0000000);
        chk("count_after_illegal", 32'(instr_count), 32'd7);
        reset_pulse();
        chk("trap_cleared", 32'({trap, trap_cause, state}), 32'd0);
        chk("count_cleared", 32'(instr_count), 32'd0);

        illegal_instr("r_alt_f3_111", 7'b0110011, 3'b111, 7'b0100000);
        reset_pulse();
        illegal_instr("slli_alt_f7", 7'b0010011, 3'b001, 7'b0100000);
        reset_pulse();

        tag = "sw_timeout"; opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
        push(1'b0, 3'd0, C_IR, 4'b0000, 4'b0000);
        push(1'b0, 3'd1, 7'b0000000, 4'b0000, 4'b0000);
        push(1'b0, 3'd2, C_SRC, 4'b0010, 4'b0000);
        for (int i = 0; i < 16; i++) push(1'b0, 3'd3, C_SRC | C_MW, 4'b0010, 4'b0000);
        for (int i = 0; i < 3; i++) push(1'b0, 3'd6, 7'b0000000, 4'b0000, FL_TMO);
        run_trace();
        chk("count_timeout", 32'(instr_count), 32'd0);
        reset_pulse();

        tag = "ecall"; opcode = 7'b1110011; funct3 = 3'b000; funct7 = 7'b0000000;
        push(1'b1, 3'd0, C_IR, 4'b0000, 4'b0000);
        push(1'b1, 3'd1, 7'b0000000, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++)
            push(1'($urandom_range(0, 1)), 3'd5, 7'b0000000, 4'b0000, FL_HALT);
        run_trace();
        reset_pulse();
        chk("halt_cleared", 32'({halted, trap, state}), 32'd0);
        chk("count_after_halt_reset", 32'(instr_count), 32'd0);

        tag = "lw_reset_in_wait"; opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
        push(1'b1, 3'd0, C_IR, 4'b0000, 4'b0000);
        push(1'b1, 3'd1, 7'b0000000, 4'b0000, 4'b0000);
        push(1'b1, 3'd2, C_SRC, 4'b0010, 4'b0000);
        push(1'b0, 3'd3, C_SRC | C_MR, 4'b0010, 4'b0000);
        push(1'b0, 3'd3, C_SRC | C_MR, 4'b0010, 4'b0000);
        run_trace();
        chk("mem_read_before_reset", 32'(mem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_abort", 32'({state, mem_read, alu_src, alu_cc}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        instr("add_after_reset", 7'b0110011, 3'b000, 7'b0000000, 0, 4'b0010, 0);
        chk("count_after_abort", 32'(instr_count), 32'd1);

        for (int i = 0; i < 6; i++)
            instr("or_fill", 7'b0110011, 3'b110, 7'b0000000, 0, 4'b0001, 0);
        chk("count_max", 32'(instr_count), 32'd7);
        instr("sltu_wrap", 7'b0110011, 3'b011, 7'b0000000, 0, 4'b1001, 0);
        chk("count_wrap", 32'(instr_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
